// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter with sticky grants. Drives a registered
//             one-hot grant plus a binary select for a downstream mux.
//             Optional macro ARB_TIMEOUT_EN adds MAX_HOLD-cycle forced hand-off.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N_REQ    = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDX_W    = $clog2(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_gnt_vld,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_preempt
);

   localparam int         PW    = IDX_W + 1;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             vld_q, vld_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic [N_REQ-1:0] cand;
   logic             owner_req;
   logic             found;
   logic [IDX_W-1:0] win;
   logic [PW-1:0]    pos;
   logic             do_grant;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          preempt_q, preempt_d;
   logic          timeout;
`else
   logic unused_max_hold;
   assign unused_max_hold = ^MAX_HOLD;
`endif

   // The current owner is masked out so a release or revocation hands off directly.
   assign cand      = i_req & ~gnt_q;
   assign owner_req = |(i_req & gnt_q);

   always_comb begin : search
      found = 1'b0;
      win   = '0;
      pos   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = PW'(ptr_q) + PW'(k);
         if (pos >= PW'(N_REQ)) begin
            pos = pos - PW'(N_REQ);
         end
         if (!found && cand[pos[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = pos[IDX_W-1:0];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   assign timeout = (cnt_q >= CW'(MAX_HOLD)) && found;
`endif

   always_comb begin : next_state
      state_d  = state_q;
      gnt_d    = gnt_q;
      vld_d    = vld_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      do_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               do_grant = 1'b1;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               if (found) begin
                  do_grant = 1'b1;
               end else begin
                  gnt_d   = '0;
                  vld_d   = 1'b0;
                  state_d = IDLE;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (timeout) begin
               do_grant  = 1'b1;
               preempt_d = 1'b1;
            end else if (cnt_q != CW'(MAX_HOLD)) begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (do_grant) begin
         state_d = GRANT;
         gnt_d   = N_REQ'(1) << win;
         vld_d   = 1'b1;
         idx_d   = win;
         ptr_d   = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
         // Counter holds the number of cycles the owner has had, including this one.
         cnt_d   = CW'(1);
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end
   assign o_preempt = preempt_q;
`else
   assign o_preempt = 1'b0;
`endif

   assign o_gnt     = gnt_q;
   assign o_gnt_vld = vld_q;
   assign o_gnt_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter
//  Purpose  : Scoreboard bench for rr_arbiter against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter;

   localparam int N        = 4;
   localparam int IW       = 2;
   localparam int MAX_HOLD = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  o_gnt;
   logic          o_gnt_vld;
   logic [IW-1:0] o_gnt_idx;
   logic          o_preempt;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic          vld;
      logic [IW-1:0] idx;
      logic          pre;
   } exp_t;
   exp_t exp_q[$];

   // Behavioural model: owner number (-1 when idle), rotate start, last index, cycles owned.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_idx   = 0;
   int m_cnt   = 0;

   rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req     (req),
      .o_gnt     (o_gnt),
      .o_gnt_vld (o_gnt_vld),
      .o_gnt_idx (o_gnt_idx),
      .o_preempt (o_preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int excl);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic take(input int w);
      m_owner = w;
      m_idx   = w;
      m_ptr   = (w + 1) % N;
      m_cnt   = 1;
   endtask

   // Apply inputs for the next edge and queue the outputs that edge must produce.
   task automatic step(input logic rn, input logic [N-1:0] r);
      exp_t e;
      int   w;
      logic pre;
      @(negedge clk);
      rst_n = rn;
      req   = r;
      pre   = 1'b0;
      if (!rn) begin
         m_owner = -1; m_ptr = 0; m_idx = 0; m_cnt = 0;
      end else if (m_owner < 0) begin
         w = pick(r, -1);
         if (w >= 0) take(w);
      end else if (!r[m_owner]) begin
         w = pick(r, m_owner);
         if (w >= 0) take(w);
         else m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_cnt >= MAX_HOLD && pick(r, m_owner) >= 0) begin
         take(pick(r, m_owner));
         pre = 1'b1;
      end
`endif
      else if (m_cnt < MAX_HOLD) begin
         m_cnt++;
      end
      e.gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e.vld = (m_owner >= 0);
      e.idx = IW'(m_idx);
      e.pre = pre;
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares every presented output against the scoreboard and tracks waiting time.
   exp_t         mon_e;
   logic [N-1:0] last_gnt = '0;
   logic         served[N];
   int           wt[N];
   logic         new_g;

   initial begin
      for (int i = 0; i < N; i++) begin
         served[i] = 1'b0;
         wt[i]     = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("gnt", 32'(o_gnt), 32'(mon_e.gnt));
         chk("gnt_vld", 32'(o_gnt_vld), 32'(mon_e.vld));
         chk("gnt_idx", 32'(o_gnt_idx), 32'(mon_e.idx));
         chk("preempt", 32'(o_preempt), 32'(mon_e.pre));
         chk("onehot", 32'($onehot0(o_gnt)), 32'(1));
         chk("vld_or", 32'(o_gnt_vld), 32'(|o_gnt));
         new_g = o_gnt_vld && (o_gnt != last_gnt);
         for (int i = 0; i < N; i++) begin
            if (!rst_n || !req[i]) begin
               served[i] = 1'b0;
               wt[i]     = 0;
            end else if (!served[i] && new_g) begin
               if (o_gnt[i]) begin
                  chk("fair_wait", 32'(wt[i] < N), 32'(1));
                  served[i] = 1'b1;
               end else begin
                  wt[i]++;
               end
            end else if (o_gnt[i]) begin
               served[i] = 1'b1;
            end
         end
         last_gnt = o_gnt;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           order[$];
      int           want[5] = '{1, 2, 4, 8, 1};
      logic [N-1:0] last;
      logic [N-1:0] r;
      int           idle;
      int           cyc;

      // Reset with all requests held, then first grant one cycle after release.
      step(1'b0, 4'b1111);
      settle();
      chk("t1_rst_gnt", 32'(o_gnt), 32'(0));
      chk("t1_rst_vld", 32'(o_gnt_vld), 32'(0));
      chk("t1_rst_idx", 32'(o_gnt_idx), 32'(0));
      step(1'b0, 4'b1111);
      step(1'b1, 4'b1111);
      settle();
      chk("t1_first", 32'(o_gnt), 32'(4'b0001));

      // Each owner releases after two grant cycles.
      order.push_back(int'(o_gnt));
      last = o_gnt;
      idle = 0;
      for (int c = 0; c < 8; c++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_cnt >= 2) r[m_owner] = 1'b0;
         step(1'b1, r);
         settle();
         if (!o_gnt_vld) idle++;
         if (o_gnt_vld && o_gnt != last) order.push_back(int'(o_gnt));
         last = o_gnt;
      end
      chk("t2_idle", 32'(idle), 32'(0));
      chk("t2_len", 32'(order.size()), 32'(5));
      for (int k = 0; k < 5 && k < order.size(); k++) begin
         chk("t2_order", 32'(order[k]), 32'(want[k]));
      end

      // Lone requester 2 for five cycles.
      step(1'b0, 4'b0000);
      cyc = 0;
      for (int c = 0; c < 7; c++) begin
         step(1'b1, (c < 5) ? 4'b0100 : 4'b0000);
         settle();
         if (o_gnt == 4'b0100 && o_gnt_idx == 2'd2) cyc++;
      end
      chk("t3_cycles", 32'(cyc), 32'(5));
      chk("t3_gnt", 32'(o_gnt), 32'(0));
      chk("t3_vld", 32'(o_gnt_vld), 32'(0));
      chk("t3_idx_hold", 32'(o_gnt_idx), 32'(2));

      // Reset mid-grant drops the owner and restarts rotation from 0.
      step(1'b0, 4'b0000);
      step(1'b1, 4'b0010);
      step(1'b1, 4'b0010);
      settle();
      chk("t4_owner1", 32'(o_gnt), 32'(4'b0010));
      step(1'b0, 4'b0011);
      settle();
      chk("t4_drop", 32'(o_gnt), 32'(0));
      step(1'b1, 4'b0011);
      settle();
      chk("t4_regrant", 32'(o_gnt), 32'(4'b0001));

`ifdef ARB_TIMEOUT_EN
      // Two persistent requesters alternate every MAX_HOLD cycles.
      step(1'b0, 4'b0000);
      for (int c = 1; c <= 34; c++) begin
         step(1'b1, 4'b0011);
         settle();
         chk("t5_gnt", 32'(o_gnt), 32'(N'(1) << (((c - 1) / MAX_HOLD) % 2)));
         chk("t5_pre", 32'(o_preempt), 32'(c > 1 && ((c - 1) % MAX_HOLD) == 0));
      end
`endif

      // Randomised traffic with occasional resets.
      step(1'b0, 4'b0000);
      r = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!r[i]) begin
               if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
            end else if (m_owner == i) begin
               if ($urandom_range(0, 2) == 0) r[i] = 1'b0;
            end else begin
               if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
            end
         end
         step(($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1, r);
      end
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);
      settle();
      chk("sb_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
